seg7_display: RTL and testbench

Downstream stage of the 0000–9999 counter: takes the counter's 16-bit binary `count` and `buzzer` and drives a 4-digit, common-anode, multiplexed seven-segment display. It re-samples `count` into the fast board-clock domain and converts it to BCD with an iterative shift-add-3 FSM. It scans the digits at a fixed refresh rate and stretches the counter's rollover pulse into a visible decimal-point flash.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/bin2bcd_iter.sv | 85 ++++++++
 rtl/seg7_display.sv | 170 +++++++++++++++++
 tb/tb_seg7_display.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, segment map and converter states
// for the 4-digit multiplexed seven-segment display.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [15:0] MAX_VAL = 16'd9999;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_MAP [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  function automatic logic [6:0] seg_encode(
    input logic [3:0] d
  );
    seg_encode = (d > 4'd9) ? SEG_BLANK
                            : SEG_MAP[d];
  endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// bin2bcd_iter: 16-bit binary to 4-digit BCD, one
// shift-add-3 step per cycle, start/done handshake.
module bin2bcd_iter
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        result_reset,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        ready,
  output logic        done,
  output logic [15:0] bcd
);

  state_t state;
  state_t state_nxt;

  logic [15:0] bin_q;
  logic [15:0] bcd_q;
  logic [15:0] bcd_adj;
  logic [3:0]  iter_q;

  always_ff @(posedge clk or posedge result_reset) begin
    if (result_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CONV;
        end
      end
      CONV: begin
        if (iter_q == 4'd15) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    done  = (state == DONE);
    bcd   = bcd_q;
  end

  // correct each nibble before the shift so it carries as decimal
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or posedge result_reset) begin
    if (result_reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
    end else if (state == IDLE && start) begin
      bin_q  <= bin;
      bcd_q  <= '0;
      iter_q <= '0;
    end else if (state == CONV) begin
      bcd_q  <= {bcd_adj[14:0], bin_q[15]};
      bin_q  <= {bin_q[14:0], 1'b0};
      iter_q <= iter_q + 4'd1;
    end
  end

endmodule

// File: rtl/seg7_display.sv
// seg7_display: count capture, BCD conversion, digit scan and
// rollover dp flash. SEG7_LZB_EN enables leading-zero blanking.
module seg7_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int FLASH_FRAMES = 250
) (
  input  logic        clk,
  input  logic        result_reset,
  input  logic [15:0] count,
  input  logic        buzzer,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int RW = (REFRESH_DIV > 1)
                    ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int DW = NUM_DIGITS * 4;

  logic [15:0] s1;
  logic [15:0] s2;
  logic [15:0] last_val;
  logic [15:0] cap_val;
  logic [15:0] sat_val;

  logic          conv_start;
  logic          conv_ready;
  logic          conv_done;
  logic [DW-1:0] conv_bcd;
  logic [DW-1:0] digit_q;

  logic [RW-1:0] refresh_q;
  logic [1:0]    idx_q;
  logic          tick;
  logic          wrap;

  logic [3:0] d0, d1, d2, d3;
  logic [3:0] cur;
  logic       blank;
  logic [6:0] seg_nxt;
  logic [3:0] an_nxt;

  logic          b1, b2, b3;
  logic          rise;
  logic [FW-1:0] flash_q;
  logic [FW-1:0] flash_nxt;

  always_ff @(posedge clk or posedge result_reset) begin
    if (result_reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= count;
      s2 <= s1;
    end
  end

  // last_val keeps the raw value so saturated inputs settle
  assign sat_val    = (s2 > MAX_VAL) ? MAX_VAL : s2;
  assign conv_start = (s1 == s2) && (s2 != last_val);

  bin2bcd_iter u_conv (
    .clk          (clk),
    .result_reset (result_reset),
    .start        (conv_start),
    .bin          (sat_val),
    .ready        (conv_ready),
    .done         (conv_done),
    .bcd          (conv_bcd)
  );

  always_ff @(posedge clk or posedge result_reset) begin
    if (result_reset) begin
      cap_val  <= '0;
      last_val <= '0;
      digit_q  <= '0;
    end else begin
      if (conv_start && conv_ready) begin
        cap_val <= s2;
      end
      if (conv_done) begin
        digit_q  <= conv_bcd;
        last_val <= cap_val;
      end
    end
  end

  assign tick = (refresh_q == RW'(REFRESH_DIV - 1));
  assign wrap = tick && (idx_q == 2'd3);

  always_ff @(posedge clk or posedge result_reset) begin
    if (result_reset) begin
      refresh_q <= '0;
      idx_q     <= '0;
    end else begin
      refresh_q <= tick ? '0 : refresh_q + RW'(1);
      if (tick) begin
        idx_q <= idx_q + 2'd1;
      end
    end
  end

  assign d0 = digit_q[3:0];
  assign d1 = digit_q[7:4];
  assign d2 = digit_q[11:8];
  assign d3 = digit_q[15:12];

  always_comb begin
    cur = d0;
    unique case (idx_q)
      2'd0: cur = d0;
      2'd1: cur = d1;
      2'd2: cur = d2;
      2'd3: cur = d3;
    endcase
    blank = 1'b0;
`ifdef SEG7_LZB_EN
    case (idx_q)
      2'd3:    blank = (d3 == 4'd0);
      2'd2:    blank = ({d3, d2} == 8'd0);
      2'd1:    blank = ({d3, d2, d1} == 12'd0);
      default: blank = 1'b0;
    endcase
`endif
    seg_nxt = blank ? SEG_BLANK : seg_encode(cur);
    an_nxt  = ~(4'b0001 << idx_q);
  end

  assign rise = b2 & ~b3;

  // a fresh rollover always restarts the full flash
  always_comb begin
    flash_nxt = flash_q;
    if (rise) begin
      flash_nxt = FW'(FLASH_FRAMES);
    end else if (wrap && flash_q != '0) begin
      flash_nxt = flash_q - FW'(1);
    end
  end

  always_ff @(posedge clk or posedge result_reset) begin
    if (result_reset) begin
      b1      <= 1'b0;
      b2      <= 1'b0;
      b3      <= 1'b0;
      flash_q <= '0;
    end else begin
      b1      <= buzzer;
      b2      <= b1;
      b3      <= b2;
      flash_q <= flash_nxt;
    end
  end

  always_ff @(posedge clk or posedge result_reset) begin
    if (result_reset) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= (flash_nxt == '0);
    end
  end

endmodule

// File: tb/tb_seg7_display.sv
// tb_seg7_display: scoreboard bench for seg7_display with
// digit-register, dp-edge and scan-frame monitors.
module tb_seg7_display;
  import seg7_pkg::*;

  localparam int RDIV = 4;
  localparam int FF   = 2;

  localparam logic [6:0] SEG_T [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef struct {
    logic [15:0] val;
    int          at;
  } dig_exp_t;

  typedef struct {
    logic dpv;
    int   at;
  } dp_exp_t;

  typedef struct {
    string       name;
    logic [27:0] segs;
  } frm_exp_t;

  logic        clk = 1'b0;
  logic        result_reset = 1'b1;
  logic [15:0] count = 16'd0;
  logic        buzzer = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int r_rel = 0;

  dig_exp_t digq[$];
  dp_exp_t  dpq[$];
  frm_exp_t frq[$];

  seg7_display #(
    .REFRESH_DIV  (RDIV),
    .FLASH_FRAMES (FF)
  ) dut (
    .clk          (clk),
    .result_reset (result_reset),
    .count        (count),
    .buzzer       (buzzer),
    .an           (an),
    .seg          (seg),
    .dp           (dp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic tick_n(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] frame_of(logic [15:0] b);
    logic [15:0] v;
    v = b;
    return {SEG_T[v[15:12]], SEG_T[v[11:8]],
            SEG_T[v[7:4]], SEG_T[v[3:0]]};
  endfunction

  function automatic int next_wrap(int l);
    return r_rel + 4 * RDIV * ((l - r_rel) / (4 * RDIV) + 1);
  endfunction

  task automatic push_dig(logic [15:0] v, int at);
    dig_exp_t e;
    e.val = v;
    e.at  = at;
    digq.push_back(e);
  endtask

  task automatic push_dp(logic v, int at);
    dp_exp_t e;
    e.dpv = v;
    e.at  = at;
    dpq.push_back(e);
  endtask

  task automatic push_frame(string name, logic [27:0] s);
    frm_exp_t e;
    e.name = name;
    e.segs = s;
    frq.push_back(e);
  endtask

  task automatic wait_dig(int lim);
    for (int i = 0; i < lim && digq.size() != 0; i++)
      @(negedge clk);
    check("dig_wait", digq.size(), 0);
    digq.delete();
  endtask

  task automatic wait_dp(int lim);
    for (int i = 0; i < lim && dpq.size() != 0; i++)
      @(negedge clk);
    check("dp_wait", dpq.size(), 0);
    dpq.delete();
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 100 && frq.size() != 0; i++)
      @(negedge clk);
    check("frame_wait", frq.size(), 0);
    frq.delete();
  endtask

  // digit register monitor: every change must be expected
  initial begin
    logic [15:0] prev_dig;
    dig_exp_t e;
    prev_dig = 16'h0000;
    forever begin
      @(negedge clk);
      if (dut.digit_q !== prev_dig) begin
        if (digq.size() == 0) begin
          check("dig_unexpected", dut.digit_q, prev_dig);
        end else begin
          e = digq.pop_front();
          check("dig_val", dut.digit_q, e.val);
          check("dig_cycle", cyc, e.at);
        end
        prev_dig = dut.digit_q;
      end
    end
  end

  // dp edge monitor
  initial begin
    logic prev_dp;
    dp_exp_t e;
    prev_dp = 1'b1;
    forever begin
      @(negedge clk);
      if (dp !== prev_dp) begin
        if (dpq.size() == 0) begin
          check("dp_unexpected", dp, prev_dp);
        end else begin
          e = dpq.pop_front();
          check("dp_val", dp, e.dpv);
          check("dp_cycle", cyc, e.at);
        end
        prev_dp = dp;
      end
    end
  end

  // frame monitor: one full scan, REFRESH_DIV samples per slot
  initial begin
    logic [3:0] prev_an;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic [3:0] bad_an;
    logic [6:0] bad_seg;
    logic [6:0] bad_exp;
    frm_exp_t   e;
    bit cap;
    bit fok;
    int k;
    int slot;
    prev_an = 4'hF;
    cap = 0;
    fok = 1;
    k = 0;
    forever begin
      @(negedge clk);
      if (cap && frq.size() == 0) cap = 0;
      if (!cap && frq.size() != 0 &&
          an == 4'b1110 && prev_an != 4'b1110) begin
        cap = 1;
        fok = 1;
        k = 0;
      end
      if (cap) begin
        slot = k / RDIV;
        exp_an = 4'b0001 << slot;
        exp_an = ~exp_an;
        exp_seg = frq[0].segs[slot*7 +: 7];
        if ((an !== exp_an || seg !== exp_seg) && fok) begin
          fok = 0;
          bad_an = an;
          bad_seg = seg;
          bad_exp = exp_seg;
        end
        k++;
        if (k == 4 * RDIV) begin
          cap = 0;
          e = frq.pop_front();
          n_tests++;
          if (!fok) begin
            n_fail++;
            $display("FAIL frame_%s: got an=%b seg=%h want seg=%h",
                     e.name, bad_an, bad_seg, bad_exp);
          end
        end
      end
      prev_an = an;
    end
  end

  initial begin
    int c0;
    int b0;
    int l2;
    bit ok;

    tick_n(3);
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    result_reset = 1'b0;
    r_rel = cyc;
`ifdef SEG7_LZB_EN
    push_frame("zero", {7'h7F, 7'h7F, 7'h7F, 7'h40});
`else
    push_frame("zero", {7'h40, 7'h40, 7'h40, 7'h40});
`endif
    wait_frame();

    tick_n(1);
    count = 16'd1234;
    push_dig(16'h1234, cyc + 20);
    wait_dig(60);
    push_frame("1234", {7'h79, 7'h24, 7'h30, 7'h19});
    wait_frame();

    tick_n(1);
    count = 16'hFFFF;
    push_dig(16'h9999, cyc + 20);
    wait_dig(60);
    push_frame("sat", {7'h10, 7'h10, 7'h10, 7'h10});
    wait_frame();
    ok = 1;
    repeat (40) begin
      @(negedge clk);
      if (dut.u_conv.state != IDLE) ok = 0;
    end
    check("no_retrigger", ok, 1);
    check("last_val_raw", dut.last_val, 16'hFFFF);

    tick_n(1);
    c0 = cyc;
    count = 16'd5;
    push_dig(16'h0005, c0 + 20);
    push_dig(16'h9999, c0 + 38);
    tick_n(11);
    check("mid_state", dut.u_conv.state == CONV, 1);
    check("mid_iter", dut.u_conv.iter_q, 8);
    count = 16'd9999;
    wait_dig(100);
    push_frame("9999", frame_of(16'h9999));
    wait_frame();

    tick_n(1);
    b0 = cyc;
    buzzer = 1'b1;
    push_dp(1'b0, b0 + 3);
    tick_n(2);
    buzzer = 1'b0;
    tick_n(6);
    buzzer = 1'b1;
    l2 = cyc + 3;
    push_dp(1'b1, next_wrap(l2) + 4 * RDIV);
    tick_n(2);
    buzzer = 1'b0;
    wait_dp(200);

    tick_n(1);
    count = 16'd4321;
    tick_n(10);
    push_dig(16'h0000, cyc);
    result_reset = 1'b1;
    #1;
    check("rst_mid_state", dut.u_conv.state == IDLE, 1);
    tick_n(2);
    result_reset = 1'b0;
    r_rel = cyc;
    push_dig(16'h4321, cyc + 20);
    wait_dig(60);
    push_frame("4321", frame_of(16'h4321));
    wait_frame();

    tick_n(1);
    count = 16'd7;
    push_dig(16'h0007, cyc + 20);
    wait_dig(60);
`ifdef SEG7_LZB_EN
    push_frame("seven", {7'h7F, 7'h7F, 7'h7F, 7'h78});
`else
    push_frame("seven", {7'h40, 7'h40, 7'h40, 7'h78});
`endif
    wait_frame();

    tick_n(1);
    count = 16'd0;
    push_dig(16'h0000, cyc + 20);
    wait_dig(60);
`ifdef SEG7_LZB_EN
    push_frame("zero2", {7'h7F, 7'h7F, 7'h7F, 7'h40});
`else
    push_frame("zero2", {7'h40, 7'h40, 7'h40, 7'h40});
`endif
    wait_frame();

    tick_n(40);
    check("dig_left", digq.size(), 0);
    check("dp_left", dpq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
